// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: shares one ROB result-write bus between the ADD and MUL units.
// Each FU result is queued in its own FIFO, then granted round-robin into a
// registered valid/ready output stage.
// Ports:
//   clk, reset (sync, active-low), flush (sync squash of everything queued or on the bus)
//   add_valid/add_tag/add_value -> add_ready : ADD result input with backpressure
//   mul_valid/mul_tag/mul_value -> mul_ready : MUL result input with backpressure
//   bus_valid/bus_tag/bus_value/bus_src <- bus_ready : result bus to the ROB (src 0=ADD, 1=MUL)
//   add_occ, mul_occ : per-source FIFO occupancy (0..DEPTH)

// result_fifo: one per-source result queue with a separate occupancy counter
module result_fifo #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_value,
  input  logic              pop,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_value,
  output logic [OW-1:0]     occ,
  output logic              ready
);
  logic [TAG_W+DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push_ok;
  // ready comes only from registered occupancy, so a full FIFO refuses even when popping
  assign ready = reset & (occ != OW'(DEPTH));
  assign push_ok = push & ready;
  assign {head_tag, head_value} = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= {push_tag, push_value};
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + OW'(push_ok) - OW'(pop);
    end
  end
endmodule

module result_bus_arbiter #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              add_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_value,
  output logic              add_ready,
  input  logic              mul_valid,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_value,
  output logic              mul_ready,
  output logic              bus_valid,
  output logic [TAG_W-1:0]  bus_tag,
  output logic [DATA_W-1:0] bus_value,
  output logic              bus_src,
  input  logic              bus_ready,
  output logic [OW-1:0]     add_occ,
  output logic [OW-1:0]     mul_occ
);
  typedef enum logic {SRC_ADD = 1'b0, SRC_MUL = 1'b1} src_t;
  src_t last_grant;
  logic [TAG_W-1:0] add_head_tag, mul_head_tag;
  logic [DATA_W-1:0] add_head_value, mul_head_value;
  logic add_ne, mul_ne, load, pop, grant_mul;
  result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_add (
    .clk(clk), .reset(reset), .flush(flush),
    .push(add_valid), .push_tag(add_tag), .push_value(add_value),
    .pop(pop & !grant_mul),
    .head_tag(add_head_tag), .head_value(add_head_value),
    .occ(add_occ), .ready(add_ready)
  );
  result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_mul (
    .clk(clk), .reset(reset), .flush(flush),
    .push(mul_valid), .push_tag(mul_tag), .push_value(mul_value),
    .pop(pop & grant_mul),
    .head_tag(mul_head_tag), .head_value(mul_head_value),
    .occ(mul_occ), .ready(mul_ready)
  );
  // The output register refills when empty or when its result is taken this cycle,
  // which sustains one result per cycle and keeps a stalled result stable.
  always_comb begin
    add_ne    = add_occ != '0;
    mul_ne    = mul_occ != '0;
    load      = !bus_valid || bus_ready;
    grant_mul = mul_ne && (!add_ne || last_grant == SRC_ADD);
    pop       = load && (add_ne || mul_ne);
  end
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      bus_valid  <= 1'b0;
      bus_tag    <= '0;
      bus_value  <= '0;
      bus_src    <= 1'b0;
      last_grant <= SRC_MUL;
    end else if (load) begin
      bus_valid <= pop;
      if (pop) begin
        bus_tag    <= grant_mul ? mul_head_tag : add_head_tag;
        bus_value  <= grant_mul ? mul_head_value : add_head_value;
        bus_src    <= grant_mul;
        last_grant <= grant_mul ? SRC_MUL : SRC_ADD;
      end
    end
  end
endmodule
